// File: rtl/id_fwd_scoreboard.sv
// id_fwd_scoreboard: ID-stage operand forwarding and load-use hazard detection over FWD_DEPTH stages.
// Optional stall bubble counter enabled by defining ID_STALL_CNT_EN.
module id_fwd_scoreboard #(
    parameter int GPR_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int FWD_DEPTH  = 3,
    parameter int LD_LAT     = 1
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        pipe_adv,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic [GPR_ADDR_W-1:0]       id_ra_addr,
    input  logic [GPR_ADDR_W-1:0]       id_rb_addr,
    input  logic                        id_use_ra,
    input  logic                        id_use_rb,
    input  logic                        id_gpr_we_,
    input  logic [GPR_ADDR_W-1:0]       id_dst_addr,
    input  logic                        id_is_load,
    input  logic [DATA_W-1:0]           gpr_data_0,
    input  logic [DATA_W-1:0]           gpr_data_1,
    input  logic [FWD_DEPTH*DATA_W-1:0] stg_data,
    input  logic                        stall_cnt_clr,
    output logic [DATA_W-1:0]           ra_data,
    output logic [DATA_W-1:0]           rb_data,
    output logic                        ld_hazard,
    output logic [31:0]                 stall_cnt
);
    logic [FWD_DEPTH-1:0]  valid_q, we_q, ld_q;
    logic [GPR_ADDR_W-1:0] dst_q [FWD_DEPTH];
    logic                  ra_pend, rb_pend;

    // Scan oldest to youngest so the lowest matching entry overrides.
    always_comb begin
        ra_data = gpr_data_0;
        rb_data = gpr_data_1;
        ra_pend = 1'b0;
        rb_pend = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && we_q[k] && dst_q[k] == id_ra_addr) begin
                ra_data = stg_data[k*DATA_W +: DATA_W];
                ra_pend = ld_q[k] && (k < LD_LAT);
            end
            if (valid_q[k] && we_q[k] && dst_q[k] == id_rb_addr) begin
                rb_data = stg_data[k*DATA_W +: DATA_W];
                rb_pend = ld_q[k] && (k < LD_LAT);
            end
        end
        ld_hazard = (id_use_ra && ra_pend) || (id_use_rb && rb_pend);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            valid_q <= '0;
            we_q    <= '0;
            ld_q    <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) dst_q[k] <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (pipe_adv) begin
            valid_q  <= {valid_q[FWD_DEPTH-2:0], id_valid && !ld_hazard};
            we_q     <= {we_q[FWD_DEPTH-2:0], ~id_gpr_we_};
            ld_q     <= {ld_q[FWD_DEPTH-2:0], id_is_load};
            dst_q[0] <= id_dst_addr;
            for (int k = 1; k < FWD_DEPTH; k++) dst_q[k] <= dst_q[k-1];
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            stall_cnt_q <= '0;
        else if (stall_cnt_clr)
            stall_cnt_q <= '0;
        else if (ld_hazard && pipe_adv && !flush && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_clr;
    assign unused_clr = stall_cnt_clr;
    assign stall_cnt  = '0;
`endif
endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// tb_id_fwd_scoreboard: directed checks of forwarding, load-use stalls, flush and the stall counter.
module tb_id_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        reset_, pipe_adv, flush, id_valid, id_use_ra, id_use_rb;
    logic        id_gpr_we_, id_is_load, stall_cnt_clr, ld_hazard;
    logic [4:0]  id_ra_addr, id_rb_addr, id_dst_addr;
    logic [31:0] gpr_data_0, gpr_data_1, ra_data, rb_data, stall_cnt;
    logic [95:0] stg_data;
    int          vecs = 0;
    int          errs = 0;

    id_fwd_scoreboard dut (
        .clk(clk), .reset_(reset_), .pipe_adv(pipe_adv), .flush(flush),
        .id_valid(id_valid), .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_gpr_we_(id_gpr_we_),
        .id_dst_addr(id_dst_addr), .id_is_load(id_is_load),
        .gpr_data_0(gpr_data_0), .gpr_data_1(gpr_data_1), .stg_data(stg_data),
        .stall_cnt_clr(stall_cnt_clr), .ra_data(ra_data), .rb_data(rb_data),
        .ld_hazard(ld_hazard), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_adv = 0; flush = 0; id_valid = 0; id_use_ra = 0; id_use_rb = 0;
        id_gpr_we_ = 1; id_is_load = 0; stall_cnt_clr = 0;
        id_ra_addr = 0; id_rb_addr = 0; id_dst_addr = 0;
        gpr_data_0 = 32'hDEAD_0000; gpr_data_1 = 32'hDEAD_0001; stg_data = '0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_ = 0;
        #2;
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL reset_hazard got %0b want 0", ld_hazard); end
        vecs++; if (stall_cnt !== 32'h0) begin errs++; $display("FAIL reset_cnt got %h want 0", stall_cnt); end
        tick();
        reset_ = 1;
        tick();
        id_use_ra = 1; id_ra_addr = 3; gpr_data_0 = 32'h11;
        id_use_rb = 1; id_rb_addr = 3; gpr_data_1 = 32'h22;
        #1;
        vecs++; if (ra_data !== 32'h11) begin errs++; $display("FAIL idle_ra got %h want 11", ra_data); end
        vecs++; if (rb_data !== 32'h22) begin errs++; $display("FAIL idle_rb got %h want 22", rb_data); end
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL idle_hazard got %0b want 0", ld_hazard); end
    endtask

    task automatic test_alu_fwd();
        do_flush();
        id_valid = 1; id_gpr_we_ = 0; id_dst_addr = 5; pipe_adv = 1;
        tick();
        id_valid = 0; pipe_adv = 0; id_use_ra = 1; id_ra_addr = 5; stg_data[31:0] = 32'hAA;
        #1;
        vecs++; if (ra_data !== 32'hAA) begin errs++; $display("FAIL alu_e0 got %h want aa", ra_data); end
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL alu_hazard got %0b want 0", ld_hazard); end
        pipe_adv = 1;
        tick();
        pipe_adv = 0; stg_data[63:32] = 32'hBB;
        #1;
        vecs++; if (ra_data !== 32'hBB) begin errs++; $display("FAIL alu_e1 got %h want bb", ra_data); end
        idle();
        id_valid = 1; id_gpr_we_ = 1; id_dst_addr = 6; pipe_adv = 1;
        tick();
        idle();
        id_use_ra = 1; id_ra_addr = 6; gpr_data_0 = 32'h66; stg_data[31:0] = 32'h99;
        #1;
        vecs++; if (ra_data !== 32'h66) begin errs++; $display("FAIL no_we got %h want 66", ra_data); end
    endtask

    task automatic test_load_use();
        do_flush();
        id_valid = 1; id_is_load = 1; id_gpr_we_ = 0; id_dst_addr = 7; pipe_adv = 1;
        tick();
        id_is_load = 0; id_dst_addr = 8; id_use_rb = 1; id_rb_addr = 7;
        #1;
        vecs++; if (ld_hazard !== 1'b1) begin errs++; $display("FAIL lu_stall got %0b want 1", ld_hazard); end
        tick();
        stg_data[63:32] = 32'h55;
        #1;
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL lu_release got %0b want 0", ld_hazard); end
        vecs++; if (rb_data !== 32'h55) begin errs++; $display("FAIL lu_rb got %h want 55", rb_data); end
        tick();
        idle();
        id_use_ra = 1; id_ra_addr = 8; id_use_rb = 1; id_rb_addr = 7;
        stg_data[31:0] = 32'h88; stg_data[63:32] = 32'h1111; stg_data[95:64] = 32'h77;
        #1;
        vecs++; if (ra_data !== 32'h88) begin errs++; $display("FAIL lu_accept got %h want 88", ra_data); end
        vecs++; if (rb_data !== 32'h77) begin errs++; $display("FAIL lu_e2 got %h want 77", rb_data); end
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL lu_e2_hazard got %0b want 0", ld_hazard); end
    endtask

    task automatic test_youngest();
        do_flush();
        id_valid = 1; id_gpr_we_ = 0; id_dst_addr = 2; pipe_adv = 1;
        tick();
        tick();
        idle();
        id_use_ra = 1; id_ra_addr = 2; stg_data[31:0] = 32'h1; stg_data[63:32] = 32'h2;
        #1;
        vecs++; if (ra_data !== 32'h1) begin errs++; $display("FAIL youngest got %h want 1", ra_data); end
    endtask

    task automatic test_last_entry_r0();
        do_flush();
        id_valid = 1; id_gpr_we_ = 0; id_dst_addr = 0; pipe_adv = 1;
        tick();
        id_valid = 0;
        tick();
        tick();
        pipe_adv = 0; id_use_ra = 1; id_ra_addr = 0; stg_data[95:64] = 32'hC2; gpr_data_0 = 32'h10;
        #1;
        vecs++; if (ra_data !== 32'hC2) begin errs++; $display("FAIL r0_e2 got %h want c2", ra_data); end
        pipe_adv = 1;
        tick();
        pipe_adv = 0;
        #1;
        vecs++; if (ra_data !== 32'h10) begin errs++; $display("FAIL drop_oldest got %h want 10", ra_data); end
    endtask

    task automatic test_stall_hold_flush();
        do_flush();
        id_valid = 1; id_is_load = 1; id_gpr_we_ = 0; id_dst_addr = 9; pipe_adv = 1;
        tick();
        id_is_load = 0; id_dst_addr = 10; id_use_ra = 1; id_ra_addr = 9; pipe_adv = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (ld_hazard !== 1'b1) begin errs++; $display("FAIL hold_%0d got %0b want 1", i, ld_hazard); end
            tick();
        end
        flush = 1; pipe_adv = 1;
        tick();
        flush = 0; pipe_adv = 0; gpr_data_0 = 32'h3C;
        #1;
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL flush_hazard got %0b want 0", ld_hazard); end
        vecs++; if (ra_data !== 32'h3C) begin errs++; $display("FAIL flush_ra got %h want 3c", ra_data); end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] four, one;
`ifdef ID_STALL_CNT_EN
        four = 32'd4; one = 32'd1;
`else
        four = 32'd0; one = 32'd0;
`endif
        do_flush();
        stall_cnt_clr = 1;
        tick();
        stall_cnt_clr = 0;
        for (int i = 0; i < 4; i++) begin
            id_valid = 1; id_is_load = 1; id_gpr_we_ = 0; id_dst_addr = 7;
            id_use_ra = 1; id_ra_addr = 7; pipe_adv = 1;
            tick();
            tick();
        end
        vecs++; if (stall_cnt !== four) begin errs++; $display("FAIL cnt_4 got %0d want %0d", stall_cnt, four); end
        idle();
        stall_cnt_clr = 1;
        tick();
        stall_cnt_clr = 0;
        #1;
        vecs++; if (stall_cnt !== 32'h0) begin errs++; $display("FAIL cnt_clr got %0d want 0", stall_cnt); end
        id_valid = 1; id_is_load = 1; id_gpr_we_ = 0; id_dst_addr = 7; id_ra_addr = 7; pipe_adv = 1;
        tick();
        id_use_ra = 1;
        tick();
        vecs++; if (stall_cnt !== one) begin errs++; $display("FAIL cnt_1 got %0d want %0d", stall_cnt, one); end
        id_use_ra = 0;
        tick();
        id_use_ra = 1; pipe_adv = 0;
        #1;
        vecs++; if (ld_hazard !== 1'b1) begin errs++; $display("FAIL pre_rst_hazard got %0b want 1", ld_hazard); end
        reset_ = 0;
        #1;
        vecs++; if (ld_hazard !== 1'b0) begin errs++; $display("FAIL async_rst_hazard got %0b want 0", ld_hazard); end
        vecs++; if (stall_cnt !== 32'h0) begin errs++; $display("FAIL async_rst_cnt got %0d want 0", stall_cnt); end
        #1;
        reset_ = 1;
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_last_entry_r0();
        test_stall_hold_flush();
        test_stall_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
